// File: rtl/prog_mem_pkg.sv
// Shared sizing, erased-word value and FSM encoding for the program memory
// port controller and its SPM page buffer.
package prog_mem_pkg;

    localparam int ADDR_W     = 14;
    localparam int DATA_W     = 16;
    localparam int PAGE_WORDS = 64;
    localparam int PAGE_W     = $clog2(PAGE_WORDS);
    localparam int PAGE_NUM_W = ADDR_W - PAGE_W;

    localparam logic [DATA_W-1:0] ERASED_WORD = 16'hFFFF;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ERASE = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

endpackage

// File: rtl/spm_page_buffer.sv
// One-page temporary buffer filled word by word by SPM; read asynchronously
// while a page write streams it out, cleared to the erased value afterwards.
module spm_page_buffer
    import prog_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [PAGE_W-1:0] wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clear,
    input  logic [PAGE_W-1:0] rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] words [PAGE_WORDS];

    // Clear has priority over fill; the controller never requests both anyway.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PAGE_WORDS; i++) begin
                words[i] <= ERASED_WORD;
            end
        end else if (clear) begin
            for (int i = 0; i < PAGE_WORDS; i++) begin
                words[i] <= ERASED_WORD;
            end
        end else if (wr_en) begin
            words[wr_idx] <= wr_data;
        end
    end

    assign rd_data = words[rd_idx];

endmodule

// File: rtl/prog_mem_spm_ctrl.sv
// Single-port program memory owner: muxes CPU fetch and the SPM page
// erase/write engine onto the memory port.
module prog_mem_spm_ctrl
    import prog_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_stall,
    input  logic              spm_fill,
    input  logic              spm_erase,
    input  logic              spm_write,
    input  logic [ADDR_W-1:0] spm_addr,
    input  logic [DATA_W-1:0] spm_data,
    output logic              spm_busy,
    output logic              spm_done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din
);

    logic [1:0]            state;
    logic [PAGE_NUM_W-1:0] page;
    logic [PAGE_W-1:0]     count;
    logic                  op_write;
    logic                  idle;
    logic                  last_word;
    logic                  fill_en;
    logic                  buf_clear;
    logic [DATA_W-1:0]     buf_rd;

    assign idle      = (state == IDLE);
    assign last_word = (count == PAGE_W'(PAGE_WORDS - 1));
    // A fill that coincides with erase/write is dropped, as are all strobes while busy.
    assign fill_en   = idle && spm_fill && !spm_erase && !spm_write;
    assign buf_clear = (state == DONE) && op_write;

    spm_page_buffer u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fill_en),
        .wr_idx  (spm_addr[PAGE_W-1:0]),
        .wr_data (spm_data),
        .clear   (buf_clear),
        .rd_idx  (count),
        .rd_data (buf_rd)
    );

    // Erase beats write when both strobe together; count wraps back to 0 on leaving.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            page     <= '0;
            count    <= '0;
            op_write <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (spm_erase) begin
                        state    <= ERASE;
                        page     <= spm_addr[ADDR_W-1:PAGE_W];
                        count    <= '0;
                        op_write <= 1'b0;
                    end else if (spm_write) begin
                        state    <= WRITE;
                        page     <= spm_addr[ADDR_W-1:PAGE_W];
                        count    <= '0;
                        op_write <= 1'b1;
                    end
                end
                ERASE, WRITE: begin
                    count <= count + 1'b1;
                    if (last_word) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign cpu_stall = !idle;
    assign spm_busy  = !idle;
    assign spm_done  = (state == DONE);

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = cpu_addr;
        mem_din  = '0;
        case (state)
            ERASE: begin
                mem_we   = 1'b1;
                mem_addr = {page, count};
                mem_din  = ERASED_WORD;
            end
            WRITE: begin
                mem_we   = 1'b1;
                mem_addr = {page, count};
                mem_din  = buf_rd;
            end
            default: ;
        endcase
    end

endmodule
